// File: rtl/mem_port_arbiter.sv
// Arbiter for the single data_memory port shared by instruction fetch (IF)
// and load/store (LS). LS has fixed priority; a saturating refusal counter
// forces an IF grant once IF has been refused STARVE_LIMIT cycles in a row.
// Read data returns one cycle after acceptance and is routed to the
// requester recorded in rsp_owner.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_rsp_valid,
    output logic [XLEN-1:0] if_rsp_data,

    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic            ls_we,
    input  logic [2:0]      ls_word_size,
    output logic            ls_rsp_valid,
    output logic [XLEN-1:0] ls_rsp_data,

    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_data_in,
    output logic            mem_write_enable,
    output logic [2:0]      mem_word_size,
    input  logic [XLEN-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
    localparam logic [2:0] SIZE_WORD = 3'b010;

    logic [3:0] starve_cnt;
    owner_t     rsp_owner;
    logic       rsp_is_store;
    logic       if_flush_q;

    logic       force_if;
    logic       grant_if;
    logic       grant_ls;

    // Arbitration: LS wins unless IF has starved long enough; nothing is
    // granted while reset is held so no write can slip through.
    always_comb begin
        force_if = (starve_cnt >= LIMIT);
        grant_if = rst & if_req_valid & (~ls_req_valid | force_if);
        grant_ls = rst & ls_req_valid & ~grant_if;
        if_req_ready = grant_if;
        ls_req_ready = grant_ls;
    end

    // Drive the memory port from whichever requester was granted; all zero when idle.
    always_comb begin
        mem_address      = '0;
        mem_data_in      = '0;
        mem_write_enable = 1'b0;
        mem_word_size    = 3'b000;
        if (grant_ls) begin
            mem_address      = ls_addr;
            mem_data_in      = ls_wdata;
            mem_write_enable = ls_we;
            mem_word_size    = ls_word_size;
        end else if (grant_if) begin
            mem_address   = if_addr;
            mem_word_size = SIZE_WORD;
        end
    end

    // Starvation counter and one-deep response tracking, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt   <= 4'd0;
            rsp_owner    <= OWN_NONE;
            rsp_is_store <= 1'b0;
            if_flush_q   <= 1'b0;
        end else begin
            if (if_req_valid & ~grant_if) begin
                if (starve_cnt != 4'hF) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end

            if (grant_if) begin
                rsp_owner <= OWN_IF;
            end else if (grant_ls) begin
                rsp_owner <= OWN_LS;
            end else begin
                rsp_owner <= OWN_NONE;
            end

            rsp_is_store <= grant_ls & ls_we;
            // A flush in the accept cycle kills the fetch that is being issued.
            if_flush_q   <= if_flush;
        end
    end

    // Response routing; a flush in the response cycle also kills the fetch,
    // and reset drops whatever is in flight.
    always_comb begin
        if_rsp_valid = rst & (rsp_owner == OWN_IF) & ~if_flush_q & ~if_flush;
        ls_rsp_valid = rst & (rsp_owner == OWN_LS);
        if_rsp_data  = if_rsp_valid ? mem_data_out : '0;
        ls_rsp_data  = (ls_rsp_valid & ~rsp_is_store) ? mem_data_out : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter with a behavioural memory
// and a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req_valid, if_req_ready, if_flush, if_rsp_valid;
    logic [XLEN-1:0] if_addr, if_rsp_data;
    logic            ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid;
    logic [XLEN-1:0] ls_addr, ls_wdata, ls_rsp_data;
    logic [2:0]      ls_word_size, mem_word_size;
    logic [XLEN-1:0] mem_address, mem_data_in, mem_data_out;
    logic            mem_write_enable;

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_addr(if_addr), .if_flush(if_flush),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_we(ls_we),
        .ls_word_size(ls_word_size),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable), .mem_word_size(mem_word_size),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural memory (word array) and reference-model state.
    logic [31:0] ram [0:255];
    int          starve     = 0;
    int          pend_owner = 0;   // 0 none, 1 fetch, 2 load/store
    bit          pend_store = 0;
    bit          pend_flush = 0;
    logic [31:0] pend_data  = 0;
    bit          exp_gi, exp_gl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check against the model, advance edge.
    task automatic step(input bit r, input bit ifv, input logic [31:0] ia, input bit fl,
                        input bit lsv, input logic [31:0] la, input logic [31:0] wd,
                        input bit we, input logic [2:0] ws);
        logic [31:0] e_addr, e_din;
        logic [2:0]  e_ws;
        bit          e_we, e_ifv, e_lsv;
        logic [31:0] s_addr, s_din;
        bit          s_we;

        rst = r; if_req_valid = ifv; if_addr = ia; if_flush = fl;
        ls_req_valid = lsv; ls_addr = la; ls_wdata = wd; ls_we = we; ls_word_size = ws;
        #1;

        exp_gi = r && ifv && (!lsv || starve >= LIMIT);
        exp_gl = r && lsv && !exp_gi;
        e_addr = 0; e_din = 0; e_we = 0; e_ws = 0;
        if (exp_gl) begin
            e_addr = la; e_din = wd; e_we = we; e_ws = ws;
        end else if (exp_gi) begin
            e_addr = ia; e_ws = 3'b010;
        end
        e_ifv = r && pend_owner == 1 && !pend_flush && !fl;
        e_lsv = r && pend_owner == 2;

        chk("if_req_ready", 32'(if_req_ready), 32'(exp_gi));
        chk("ls_req_ready", 32'(ls_req_ready), 32'(exp_gl));
        chk("mem_address", mem_address, e_addr);
        chk("mem_data_in", mem_data_in, e_din);
        chk("mem_write_enable", 32'(mem_write_enable), 32'(e_we));
        chk("mem_word_size", 32'(mem_word_size), 32'(e_ws));
        chk("if_rsp_valid", 32'(if_rsp_valid), 32'(e_ifv));
        chk("if_rsp_data", if_rsp_data, e_ifv ? pend_data : 32'h0);
        chk("ls_rsp_valid", 32'(ls_rsp_valid), 32'(e_lsv));
        chk("ls_rsp_data", ls_rsp_data, (e_lsv && !pend_store) ? pend_data : 32'h0);
        chk("starve_cnt", 32'(dut.starve_cnt), 32'(starve));

        s_addr = mem_address; s_din = mem_data_in; s_we = mem_write_enable;
        @(posedge clk);
        // Memory: registered read of the presented address, write at the edge.
        mem_data_out = ram[s_addr[9:2]];
        if (s_we) ram[s_addr[9:2]] = s_din;

        if (!r) begin
            starve = 0; pend_owner = 0; pend_store = 0; pend_flush = 0; pend_data = 0;
        end else begin
            pend_owner = exp_gi ? 1 : (exp_gl ? 2 : 0);
            pend_store = exp_gl && we;
            pend_flush = fl;
            pend_data  = mem_data_out;
            if (ifv && !exp_gi) starve = (starve < 15) ? starve + 1 : 15;
            else                starve = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit r);
        step(r, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    endtask

    bit          h_ifv, h_lsv, h_we, h_fl, h_rst;
    logic [31:0] h_ia, h_la, h_wd;
    logic [2:0]  h_ws;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        ram[32'h10 >> 2] = 32'hDEADBEEF;
        ram[0]           = 32'hCAFEF00D;
        mem_data_out = 0;
        rst = 0; if_req_valid = 0; if_addr = 0; if_flush = 0;
        ls_req_valid = 0; ls_addr = 0; ls_wdata = 0; ls_we = 0; ls_word_size = 0;

        // Reset with requests pending: nothing may be granted or written.
        step(0, 1, 32'h40, 0, 1, 32'h44, 32'h55, 1, 3'b010);
        idle(0);
        idle(1);

        // LS-only load.
        step(1, 0, 0, 0, 1, 32'h10, 0, 0, 3'b010);
        idle(1);

        // Store then load back-to-back.
        step(1, 0, 0, 0, 1, 32'h20, 32'h12345678, 1, 3'b010);
        step(1, 0, 0, 0, 1, 32'h20, 0, 0, 3'b010);
        idle(1);

        // Reset mid-access drops the in-flight response.
        step(1, 0, 0, 0, 1, 32'h10, 0, 0, 3'b010);
        idle(0);
        step(1, 0, 0, 0, 1, 32'h10, 0, 0, 3'b010);
        idle(1);

        // Starvation: both valid continuously, 4:1 pattern.
        for (int i = 0; i < 12; i++)
            step(1, 1, 32'h0, 0, 1, 32'h10, 0, 0, 3'b010);
        idle(1);

        // Flush in response cycle with concurrent LS grant.
        step(1, 1, 32'h0, 0, 0, 0, 0, 0, 3'b000);
        step(1, 0, 0, 1, 1, 32'h10, 0, 0, 3'b010);
        idle(1);
        // Flush in accept cycle.
        step(1, 1, 32'h0, 1, 0, 0, 0, 0, 3'b000);
        idle(1);
        // Unflushed fetch delivers.
        step(1, 1, 32'h0, 0, 0, 0, 0, 0, 3'b000);
        idle(1);
        idle(1);

        // Random traffic, requests held stable until accepted.
        h_ifv = 0; h_lsv = 0; h_ia = 0; h_la = 0; h_wd = 0; h_we = 0; h_ws = 0;
        for (int c = 0; c < 600; c++) begin
            if (!h_ifv) begin
                h_ifv = ($urandom_range(0, 3) != 0);
                h_ia  = {22'b0, 10'($urandom_range(0, 1023))};
            end
            if (!h_lsv) begin
                h_lsv = ($urandom_range(0, 2) != 0);
                h_la  = {22'b0, 10'($urandom_range(0, 1023))};
                h_wd  = $urandom;
                h_we  = ($urandom_range(0, 1) == 1);
                h_ws  = 3'($urandom_range(0, 7));
            end
            h_fl  = ($urandom_range(0, 5) == 0);
            h_rst = ($urandom_range(0, 49) != 0);
            step(h_rst, h_ifv, h_ia, h_fl, h_lsv, h_la, h_wd, h_we, h_ws);
            if (exp_gi) h_ifv = 0;
            if (exp_gl) h_lsv = 0;
        end
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
